// File: rtl/onn_convergence_monitor.sv
// Watches the neuron bank once per period, declares convergence or timeout, and captures the final phases.
// Registered outputs reflect a tick one edge after it is sampled. There is no backpressure: every tick in RUN is consumed.
module onn_convergence_monitor #(
    parameter int n              = 210,
    parameter int PW             = 4,
    parameter int STABLE_PERIODS = 3,
    parameter int MAX_PERIODS    = 1024
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    period_tick,
    input  logic [0:n-1]            state_changed,
    input  logic [0:PW*n-1]         phi_out,
    output logic                    busy,
    output logic                    done,
    output logic                    converged,
    output logic                    timed_out,
    output logic                    drop,
    output logic [0:PW*n-1]         final_phase,
    output logic [15:0]             period_count,
    output logic [$clog2(n+1)-1:0]  changed_count
);
    localparam int CW = $clog2(n+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [7:0]      stable_cnt, stable_nxt;
    logic [15:0]     period_nxt;
    logic [CW-1:0]   changed_nxt;
    logic            converged_nxt, timed_out_nxt;
    logic [0:PW*n-1] final_nxt;
    logic [CW-1:0]   popcnt;

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < n; i++) begin
            popcnt = popcnt + CW'(state_changed[i]);
        end
    end

    always_comb begin
        state_nxt     = state;
        stable_nxt    = stable_cnt;
        period_nxt    = period_count;
        changed_nxt   = changed_count;
        converged_nxt = converged;
        timed_out_nxt = timed_out;
        final_nxt     = final_phase;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt     = RUN;
                    stable_nxt    = '0;
                    period_nxt    = '0;
                    changed_nxt   = '0;
                    converged_nxt = 1'b0;
                    timed_out_nxt = 1'b0;
                    final_nxt     = '0;
                end
            end
            RUN: begin
                if (period_tick) begin
                    changed_nxt = popcnt;
                    period_nxt  = (period_count == 16'hFFFF) ? period_count : period_count + 16'd1;
                    if (|state_changed)
                        stable_nxt = '0;
                    else
                        stable_nxt = (stable_cnt == 8'hFF) ? stable_cnt : stable_cnt + 8'd1;
                    // Stability is tested first so it wins a same-tick tie with the budget.
                    if (stable_nxt == 8'(STABLE_PERIODS)) begin
                        converged_nxt = 1'b1;
                        final_nxt     = phi_out;
                        state_nxt     = DONE;
                    end else if (period_nxt == 16'(MAX_PERIODS)) begin
                        timed_out_nxt = 1'b1;
                        final_nxt     = phi_out;
                        state_nxt     = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            stable_cnt    <= '0;
            period_count  <= '0;
            changed_count <= '0;
            converged     <= 1'b0;
            timed_out     <= 1'b0;
            final_phase   <= '0;
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt == RUN);
            done          <= (state_nxt == DONE);
            stable_cnt    <= stable_nxt;
            period_count  <= period_nxt;
            changed_count <= changed_nxt;
            converged     <= converged_nxt;
            timed_out     <= timed_out_nxt;
            final_phase   <= final_nxt;
        end
    end

    assign drop = done;

endmodule

// File: tb/tb_onn_convergence_monitor.sv
// Directed bench: unit A uses a 10-period budget, unit B a 3-period budget for the tie case.
module tb_onn_convergence_monitor;
    logic        sclk = 1'b0;
    logic        rst  = 1'b0;
    logic        start = 1'b0;
    logic        period_tick = 1'b0;
    logic [0:7]  state_changed = '0;
    logic [0:31] phi_out = '0;

    logic        busy_a, done_a, conv_a, to_a, drop_a;
    logic [0:31] fp_a;
    logic [15:0] pc_a;
    logic [3:0]  cc_a;
    logic        busy_b, done_b, conv_b, to_b, drop_b;
    logic [0:31] fp_b;
    logic [15:0] pc_b;
    logic [3:0]  cc_b;

    int total  = 0;
    int passed = 0;

    onn_convergence_monitor #(.n(8), .PW(4), .STABLE_PERIODS(3), .MAX_PERIODS(10)) dut_a (
        .sclk(sclk), .rst(rst), .start(start), .period_tick(period_tick),
        .state_changed(state_changed), .phi_out(phi_out),
        .busy(busy_a), .done(done_a), .converged(conv_a), .timed_out(to_a), .drop(drop_a),
        .final_phase(fp_a), .period_count(pc_a), .changed_count(cc_a)
    );

    onn_convergence_monitor #(.n(8), .PW(4), .STABLE_PERIODS(3), .MAX_PERIODS(3)) dut_b (
        .sclk(sclk), .rst(rst), .start(start), .period_tick(period_tick),
        .state_changed(state_changed), .phi_out(phi_out),
        .busy(busy_b), .done(done_b), .converged(conv_b), .timed_out(to_b), .drop(drop_b),
        .final_phase(fp_b), .period_count(pc_b), .changed_count(cc_b)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge so each tick straddles exactly one rising edge.
    task automatic tick(input logic [7:0] chg, input logic [31:0] phi);
        @(negedge sclk);
        period_tick   = 1'b1;
        state_changed = chg;
        phi_out       = phi;
        @(negedge sclk);
        period_tick   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge sclk);
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            start = ~start;
            period_tick = ~period_tick;
            state_changed = ~state_changed;
            phi_out = ~phi_out;
        end
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_conv", conv_a, 0);
        chk("rst_to", to_a, 0);
        chk("rst_drop", drop_a, 0);
        chk("rst_fp", fp_a, 0);
        chk("rst_pc", pc_a, 0);
        chk("rst_cc", cc_a, 0);
        @(negedge sclk);
        start = 1'b0; period_tick = 1'b0; state_changed = '0; phi_out = '0;
        rst = 1'b0;

        tick(8'hFF, 32'h1111_1111);
        tick(8'hFF, 32'h2222_2222);
        chk("idle_pc", pc_a, 0);
        chk("idle_busy", busy_a, 0);
        chk("idle_cc", cc_a, 0);

        // Convergence
        pulse_start();
        chk("cv_busy0", busy_a, 1);
        chk("cv_pc0", pc_a, 0);
        tick(8'hFF, 32'hDEAD_BEEF);
        chk("cv_cc1", cc_a, 8);
        tick(8'h03, 32'hDEAD_BEEF);
        chk("cv_cc2", cc_a, 2);
        tick(8'h00, 32'hDEAD_BEEF);
        tick(8'h00, 32'hDEAD_BEEF);
        chk("cv_done4", done_a, 0);
        tick(8'h00, 32'h0123_4567);
        chk("cv_conv", conv_a, 1);
        chk("cv_done", done_a, 1);
        chk("cv_drop", drop_a, 1);
        chk("cv_busy", busy_a, 0);
        chk("cv_to", to_a, 0);
        chk("cv_pc", pc_a, 5);
        chk("cv_cc", cc_a, 0);
        chk("cv_fp", fp_a, 32'h0123_4567);
        tick(8'hFF, 32'h5555_5555);
        chk("done_pc_hold", pc_a, 5);
        chk("done_fp_hold", fp_a, 32'h0123_4567);

        // Restart from DONE, then stability reset pattern
        pulse_start();
        chk("rs_busy", busy_a, 1);
        chk("rs_done", done_a, 0);
        chk("rs_pc", pc_a, 0);
        chk("rs_fp", fp_a, 0);
        chk("rs_conv", conv_a, 0);
        tick(8'h00, 32'h0); chk("sr_cc1", cc_a, 0);
        tick(8'h00, 32'h0); chk("sr_cc2", cc_a, 0);
        chk("sr_done2", done_a, 0);
        tick(8'h01, 32'h0); chk("sr_cc3", cc_a, 1);
        tick(8'h00, 32'h0); chk("sr_cc4", cc_a, 0);
        tick(8'h00, 32'h0); chk("sr_cc5", cc_a, 0);
        chk("sr_done5", done_a, 0);
        tick(8'h00, 32'hCAFE_0006); chk("sr_cc6", cc_a, 0);
        chk("sr_conv", conv_a, 1);
        chk("sr_pc", pc_a, 6);
        chk("sr_fp", fp_a, 32'hCAFE_0006);

        // Timeout, with a stray start in RUN
        pulse_start();
        for (int i = 1; i <= 4; i++) tick(8'h01, 32'h1000_0000 + 32'(i));
        pulse_start();
        chk("run_start_pc", pc_a, 4);
        chk("run_start_busy", busy_a, 1);
        for (int i = 5; i <= 9; i++) tick(8'h01, 32'h1000_0000 + 32'(i));
        chk("to_done9", done_a, 0);
        chk("to_pc9", pc_a, 9);
        tick(8'h01, 32'h1000_000A);
        chk("to_to", to_a, 1);
        chk("to_conv", conv_a, 0);
        chk("to_done", done_a, 1);
        chk("to_pc", pc_a, 10);
        chk("to_cc", cc_a, 1);
        chk("to_fp", fp_a, 32'h1000_000A);

        // Simultaneous terminate on the 3-period unit
        pulse_start();
        tick(8'h00, 32'hAAAA_0001);
        tick(8'h00, 32'hAAAA_0002);
        chk("sim_done2", done_b, 0);
        tick(8'h00, 32'hAAAA_0003);
        chk("sim_conv", conv_b, 1);
        chk("sim_to", to_b, 0);
        chk("sim_pc", pc_b, 3);
        chk("sim_fp", fp_b, 32'hAAAA_0003);

        // Asynchronous abort mid-run
        pulse_start();
        for (int i = 1; i <= 4; i++) tick(8'h01, 32'h7777_0000 + 32'(i));
        chk("ab_pc_pre", pc_a, 4);
        #2 rst = 1'b1;
        #1;
        chk("ab_busy", busy_a, 0);
        chk("ab_done", done_a, 0);
        chk("ab_pc", pc_a, 0);
        chk("ab_cc", cc_a, 0);
        chk("ab_fp", fp_a, 0);
        @(negedge sclk);
        rst = 1'b0;
        @(negedge sclk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
